// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver constants, FSM state type and the frame parity helper.
package ps2_pkg;

    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned BIT_START  = 0;
    localparam int unsigned BIT_PARITY = 9;
    localparam int unsigned BIT_STOP   = 10;

    localparam int unsigned DEFAULT_FILTER_LEN     = 8;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 50000;

    localparam logic [7:0] SCAN_BREAK = 8'hF0;
    localparam logic [7:0] SCAN_A     = 8'h1C;
    localparam logic [7:0] SCAN_Z     = 8'h1A;

    typedef enum logic [1:0] {
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchronizes the PS/2 clock and data pins, debounces the clock and emits a
// one-cycle strobe on each filtered falling edge.
module ps2_sync_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = DEFAULT_FILTER_LEN
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_data_sync,
    output logic o_fall_strobe
);

    localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic            r_clk_meta;
    logic            r_clk_sync;
    logic            r_dat_meta;
    logic            r_dat_sync;
    logic [CntW-1:0] r_filt_cnt;
    logic            r_filt_clk;
    logic            r_strobe;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
            r_filt_cnt <= '0;
            r_filt_clk <= 1'b1;
            r_strobe   <= 1'b0;
        end else begin
            r_clk_meta <= i_ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_dat_meta <= i_ps2_data;
            r_dat_sync <= r_dat_meta;
            r_strobe   <= 1'b0;
            // The filtered level only follows after FILTER_LEN differing samples in a row.
            if (r_clk_sync == r_filt_clk) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == CntW'(FILTER_LEN - 1)) begin
                r_filt_cnt <= '0;
                r_filt_clk <= r_clk_sync;
                r_strobe   <= ~r_clk_sync;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    assign o_data_sync   = r_dat_sync;
    assign o_fall_strobe = r_strobe;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host frame receiver: bit FSM with parity/stop check, idle
// timeout, and a scan-code holding register acknowledged by read.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = DEFAULT_FILTER_LEN,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clock50,
    input  logic       reset,
    input  logic       keyboard_clk,
    input  logic       keyboard_data,
    input  logic       read,
    output logic       scan_ready,
    output logic [7:0] scan_code
);

    localparam int unsigned BitW  = $clog2(FRAME_BITS);
    localparam int unsigned IdleW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic             w_data;
    logic             w_strobe;
    logic             w_timeout;
    logic             w_accept;
    rx_state_e        r_state;
    rx_state_e        w_state_d;
    logic [BitW-1:0]  r_bit_cnt;
    logic [BitW-1:0]  w_bit_cnt_d;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_d;
    logic             r_parity;
    logic             w_parity_d;
    logic [IdleW-1:0] r_idle_cnt;
    logic             r_scan_ready;
    logic [7:0]       r_scan_code;

    ps2_sync_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_sync_filter (
        .i_clk        (clock50),
        .i_rst        (reset),
        .i_ps2_clk    (keyboard_clk),
        .i_ps2_data   (keyboard_data),
        .o_data_sync  (w_data),
        .o_fall_strobe(w_strobe)
    );

    assign w_timeout = (r_state != StStart) && !w_strobe &&
                       (r_idle_cnt == IdleW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock50) begin
        if (reset) begin
            r_state    <= StStart;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_idle_cnt <= '0;
        end else begin
            r_state   <= w_state_d;
            r_bit_cnt <= w_bit_cnt_d;
            r_shift   <= w_shift_d;
            r_parity  <= w_parity_d;
            if (r_state == StStart || w_strobe || w_timeout) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_bit_cnt_d = r_bit_cnt;
        w_shift_d   = r_shift;
        w_parity_d  = r_parity;
        if (w_timeout) begin
            w_state_d   = StStart;
            w_bit_cnt_d = '0;
        end else if (w_strobe) begin
            unique case (r_state)
                StStart: begin
                    // A high start bit is line noise; stay put.
                    if (!w_data) begin
                        w_state_d   = StData;
                        w_bit_cnt_d = BitW'(BIT_START + 1);
                    end
                end
                StData: begin
                    w_shift_d   = {w_data, r_shift[7:1]};
                    w_bit_cnt_d = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == BitW'(BIT_PARITY - 1)) begin
                        w_state_d = StParity;
                    end
                end
                StParity: begin
                    w_parity_d  = w_data;
                    w_bit_cnt_d = r_bit_cnt + 1'b1;
                    w_state_d   = StStop;
                end
                StStop: begin
                    w_state_d   = StStart;
                    w_bit_cnt_d = '0;
                end
                default: begin
                    w_state_d   = StStart;
                    w_bit_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_accept = w_strobe && (r_state == StStop) && (r_bit_cnt == BitW'(BIT_STOP)) &&
                   w_data && odd_parity_ok(r_shift, r_parity);
    end

    // Accept has priority over read so a same-edge acknowledge cannot drop a new byte.
    always_ff @(posedge clock50) begin
        if (reset) begin
            r_scan_ready <= 1'b0;
            r_scan_code  <= 8'h00;
        end else if (w_accept) begin
            r_scan_ready <= 1'b1;
            r_scan_code  <= r_shift;
        end else if (read) begin
            r_scan_ready <= 1'b0;
        end
    end

    assign scan_ready = r_scan_ready;
    assign scan_code  = r_scan_code;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: bit-banged PS/2 frames with a scoreboard
// of expected scan codes, using a shortened bit period and timeout.
module tb_ps2_keyboard_rx;
    import ps2_pkg::*;

    localparam int unsigned FILT = 8;
    localparam int unsigned TMO  = 400;
    localparam int unsigned HALF = 20;

    localparam int M_BADPAR  = 1;
    localparam int M_BADSTOP = 2;
    localparam int M_GLITCH  = 4;
    localparam int M_MEASURE = 8;
    localparam int M_READACC = 16;

    logic       clock50       = 1'b0;
    logic       reset         = 1'b1;
    logic       keyboard_clk  = 1'b1;
    logic       keyboard_data = 1'b1;
    logic       read          = 1'b0;
    logic       scan_ready;
    logic [7:0] scan_code;

    int         vectors     = 0;
    int         miscompares = 0;
    int         lat         = 0;
    logic [7:0] exp_q[$];

    ps2_keyboard_rx #(
        .FILTER_LEN    (FILT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock50      (clock50),
        .reset        (reset),
        .keyboard_clk (keyboard_clk),
        .keyboard_data(keyboard_data),
        .read         (read),
        .scan_ready   (scan_ready),
        .scan_code    (scan_code)
    );

    always #10 clock50 = ~clock50;

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock50);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        assert (got === expv)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic expect_accept(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed empty scoreboard expected one pending byte", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_code"}, 32'(scan_code), 32'(e));
            chk({tag, "_ready"}, 32'(scan_ready), 32'd1);
        end
    endtask

    task automatic pulse_read();
        @(negedge clock50);
        read = 1'b1;
        @(negedge clock50);
        read = 1'b0;
    endtask

    // Sends the first nbits of a frame; stop-bit low phase optionally measures
    // accept latency or raises read on the previously measured accept edge.
    task automatic send_frame(input logic [7:0] d, input int mode, input int nbits);
        logic [10:0] bits;
        logic        par;
        bit          seen;
        seen = 1'b0;
        par  = ~(^d);
        if ((mode & M_BADPAR) != 0) par = ~par;
        bits = {((mode & M_BADSTOP) != 0) ? 1'b0 : 1'b1, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clock50);
            keyboard_data = bits[i];
            if ((mode & M_GLITCH) != 0) begin
                wait_cycles(13);
                keyboard_clk = 1'b0;
                wait_cycles(3);
                keyboard_clk = 1'b1;
                wait_cycles(HALF - 17);
            end else begin
                wait_cycles(HALF - 1);
            end
            @(negedge clock50);
            keyboard_clk = 1'b0;
            if (i == 10) begin
                for (int c = 1; c <= int'(HALF); c++) begin
                    if ((mode & M_READACC) != 0 && c == lat) read = 1'b1;
                    @(posedge clock50);
                    #1;
                    if ((mode & M_MEASURE) != 0 && !seen && scan_ready) begin
                        lat  = c;
                        seen = 1'b1;
                    end
                    @(negedge clock50);
                    read = 1'b0;
                end
            end else if ((mode & M_GLITCH) != 0) begin
                wait_cycles(13);
                keyboard_clk = 1'b1;
                wait_cycles(3);
                keyboard_clk = 1'b0;
                wait_cycles(HALF - 16);
            end else begin
                wait_cycles(HALF);
            end
            keyboard_clk = 1'b1;
        end
        @(negedge clock50);
        keyboard_data = 1'b1;
        wait_cycles(HALF);
    endtask

    initial begin
        wait_cycles(5);
        reset = 1'b0;
        wait_cycles(2);
        chk("reset_ready", 32'(scan_ready), 32'd0);
        chk("reset_code", 32'(scan_code), 32'h00);

        exp_q.push_back(SCAN_A);
        send_frame(SCAN_A, M_MEASURE, 11);
        expect_accept("first_1c");
        chk("accept_latency_in_window", 32'(lat >= int'(FILT) + 2 && lat <= int'(FILT) + 4), 32'd1);
        pulse_read();
        chk("read_clears_ready", 32'(scan_ready), 32'd0);
        chk("read_keeps_code", 32'(scan_code), 32'h1C);

        exp_q.push_back(SCAN_BREAK);
        send_frame(SCAN_BREAK, 0, 11);
        expect_accept("break_f0");
        pulse_read();
        chk("break_read", 32'(scan_ready), 32'd0);
        exp_q.push_back(SCAN_A);
        send_frame(SCAN_A, 0, 11);
        expect_accept("break_1c");
        pulse_read();

        send_frame(8'h32, M_BADPAR, 11);
        chk("badpar_ready", 32'(scan_ready), 32'd0);
        chk("badpar_code", 32'(scan_code), 32'h1C);
        send_frame(8'h32, M_BADSTOP, 11);
        chk("badstop_ready", 32'(scan_ready), 32'd0);
        chk("badstop_code", 32'(scan_code), 32'h1C);
        exp_q.push_back(8'h32);
        send_frame(8'h32, 0, 11);
        expect_accept("good_32");
        pulse_read();

        // Start bit plus five data bits, then idle well past the timeout.
        send_frame(8'hAA, 0, 6);
        wait_cycles(1000);
        chk("partial_ready", 32'(scan_ready), 32'd0);
        exp_q.push_back(8'h2B);
        send_frame(8'h2B, 0, 11);
        expect_accept("after_timeout_2b");
        pulse_read();

        exp_q.push_back(SCAN_Z);
        send_frame(SCAN_Z, M_GLITCH, 11);
        expect_accept("glitch_1a");
        pulse_read();

        exp_q.push_back(8'h15);
        send_frame(8'h15, 0, 11);
        expect_accept("unread_15");
        exp_q.push_back(8'h1D);
        send_frame(8'h1D, M_READACC, 11);
        expect_accept("overrun_1d");
        pulse_read();
        chk("overrun_read", 32'(scan_ready), 32'd0);

        send_frame(8'h77, 0, 5);
        @(negedge clock50);
        reset = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(2);
        chk("midreset_ready", 32'(scan_ready), 32'd0);
        chk("midreset_code", 32'(scan_code), 32'h00);
        exp_q.push_back(SCAN_Z);
        send_frame(SCAN_Z, 0, 11);
        expect_accept("post_reset_1a");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

PS/2 keyboard receiver that deserializes device-to-host frames and presents one scan-code byte at a time to the rest of the design. It sits between the board's PS2_CLK/PS2_DAT pins and the scan-code consumer. The consumer (history register plus a one-shot pulser) acknowledges each byte with a `read` pulse. Everything runs in the `clock50` domain; the PS/2 pins are treated as asynchronous inputs.

## Interface
Parameters:
- FILTER_LEN, 8: consecutive equal samples required before the filtered PS/2 clock changes level.
- TIMEOUT_CYCLES, 50000: idle `clock50` cycles mid-frame before a partial frame is discarded (1 ms at 50 MHz).

Ports:
- clock50  input  1  system clock, 50 MHz; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- keyboard_clk  input  1  raw PS/2 clock from the device (asynchronous).
- keyboard_data  input  1  raw PS/2 data from the device (asynchronous).
- read  input  1  one-cycle acknowledge from the consumer; clears `scan_ready`.
- scan_ready  output  1  high while `scan_code` holds an unacknowledged byte.
- scan_code  output  8  last valid received data byte.

## Operation
- `keyboard_clk` and `keyboard_data` each pass through a 2-FF synchronizer.
- The synchronized clock goes through a FILTER_LEN-sample glitch filter.
- A falling edge of the filtered clock is a bit strobe. Data is sampled from the synchronized data line on that strobe.
- Frame format is 11 bits: start=0, D0..D7 (LSB first), odd parity, stop=1.
- Bit counter values:
  - Counter 0 expects the start bit. If the start bit reads 1, the strobe is ignored and the counter stays 0.
  - Counters 1..8 shift data into an 8-bit register, LSB first.
  - Counter 9 captures parity.
  - Counter 10 checks the stop bit.
- Frame complete (counter 10 strobe):
  - Accept if stop==1 and XOR(D0..D7, parity)==1. On accept, load `scan_code` and set `scan_ready`.
  - Otherwise discard silently.
  - In both cases the counter returns to 0.
- Timeout: an idle counter runs while the bit counter is nonzero and resets on each strobe. Reaching TIMEOUT_CYCLES forces the bit counter to 0 and discards the partial frame.
- `read` clears `scan_ready`. It has no effect on `scan_code`.
- Overrun: a frame accepted while `scan_ready` is already high overwrites `scan_code` and leaves `scan_ready` high. No error flag.
- Host-to-device transmission (inhibit, commands) is not supported. Both pins are input-only.

## Timing
- Reset values:
  - `scan_ready` = 0, `scan_code` = 8'h00.
  - Bit counter, shift register, idle counter and filter = 0.
  - Filtered clock = 1 (idle).
- Reset mid-frame abandons the frame. The next frame is received normally.
- Latency from the raw `keyboard_clk` falling edge to the strobe is 2 synchronizer cycles plus FILTER_LEN cycles.
- `scan_code` and `scan_ready` update on the `clock50` edge immediately after the stop-bit strobe.
- `read` high at edge N: `scan_ready` is 0 after edge N.
- Simultaneous `read` and frame accept on the same edge: the accept wins. `scan_ready` = 1 and `scan_code` = new byte.
- Glitches shorter than FILTER_LEN cycles on `keyboard_clk` produce no strobe.

## Structure
- Shared package `ps2_pkg`:
  - FRAME_BITS=11 and bit-index constants (START=0, PARITY=9, STOP=10).
  - Default FILTER_LEN and TIMEOUT_CYCLES.
  - Common scan-code constants used by consumers: BREAK=8'hF0, A=8'h1C, Z=8'h1A.
- One sub-module, `ps2_sync_filter`: synchronizer plus glitch filter plus falling-edge strobe for the clock line. It also provides the synchronized data output.
- Top level holds the frame FSM (bit counter, shift register, parity check, timeout) and the output register.

## Test plan
- Reset, then a valid frame for 8'h1C (PS/2 bit period 80 µs) -> `scan_code`=8'h1C, `scan_ready`=1 one cycle after the stop strobe. A `read` pulse then clears `scan_ready`; `scan_code` stays 8'h1C.
- Break sequence: frames 8'hF0 then 8'h1C, each acknowledged with `read` -> two `scan_ready` assertions carrying 8'hF0 then 8'h1C.
- Frame 8'h32 with wrong parity, or with stop=0 -> `scan_ready` stays 0 and `scan_code` keeps its prior value. A following valid 8'h32 frame is accepted.
- 5 data bits sent, then 2 ms idle, then a full 8'h2B frame -> only 8'h2B is reported; the partial frame is discarded by the timeout.
- 3-cycle glitch pulses on `keyboard_clk` during a valid 8'h1A frame -> 8'h1A received intact.
- Overrun and same-edge case: 8'h15 left unread, then 8'h1D arrives with `read` asserted on the accept edge -> `scan_code`=8'h1D and `scan_ready`=1. Also assert `reset` mid-frame -> outputs return to 0 and the next frame decodes correctly.
